serial_mag_comp: RTL
====================

Name: serial_mag_comp

Overview:
- Multi-digit magnitude comparator for WIDTH-bit unsigned operands.
- Scans two bits per clock, MSB digit first, and stops at the first differing digit.
- Produces the same one-hot less/equal/greater relation as the 2-bit comparator slice, extended to wide operands.
- Sits between a requester that issues start/operands and logic that consumes a registered relation with a done pulse.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2 (elaboration-time error otherwise).
- NDIG, WIDTH/2, derived digit count; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- busy  output  1  high while scanning.
- done  output  1  one-cycle pulse when the result becomes valid.
- lt  output  1  A < B.
- eq  output  1  A == B.
- gt  output  1  A > B.

Behaviour:
- Reset (rst high at an edge): state IDLE; busy=0, done=0, lt=eq=gt=0; shift registers and digit counter cleared.
- Reset mid-scan aborts the comparison. No done pulse is issued. Outputs return to reset values at that edge.
- States: IDLE, SCAN.
- IDLE + start=1 at edge t0:
  - a and b load into shift registers sa and sb.
  - Digit counter is set to NDIG-1.
  - lt/eq/gt clear to 000.
  - busy=1 after t0; state goes to SCAN.
- IDLE + start=0: hold all registers; done=0.
- SCAN, at each edge: compare sa[WIDTH-1:WIDTH-2] against sb[WIDTH-1:WIDTH-2] using the 2-bit slice.
  - Digits differ: register lt or gt (exactly one set, eq=0); done=1; busy=0; go to IDLE.
  - Digits equal and counter==0: register eq=1; done=1; busy=0; go to IDLE.
  - Digits equal and counter>0: shift sa and sb left by 2 (zero fill); decrement counter; stay in SCAN.
- Latency: if the first differing digit is digit d (d=1 is the MSB digit, d=1..NDIG), done is asserted after edge t0+d. Equal operands take d=NDIG.
  - Minimum latency is 1 cycle after acceptance; maximum is NDIG cycles.
- done is high for exactly one cycle and is 0 at every other time.
- lt/eq/gt:
  - Hold the last result until the next accepted start or reset.
  - Are one-hot whenever a result is valid.
  - Are 000 from acceptance until the decision.
- start while busy=1 is ignored: no restart, operands not re-captured.
- Changes on a/b after acceptance have no effect.
- start=1 in the same cycle done=1: the state is IDLE, so the start is accepted at the next edge. The previous result clears at that edge.
- Back-to-back comparisons therefore have zero idle cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Package serial_mag_comp_pkg:
  - state enum (IDLE, SCAN).
  - rel_t one-hot struct/encoding {lt, eq, gt}.
  - constants REL_LT=3'b100, REL_EQ=3'b010, REL_GT=3'b001, REL_NONE=3'b000.
- Sub-module comp_digit2:
  - Purely combinational 2-bit unsigned compare.
  - Inputs: two 2-bit digits. Output: rel_t one-hot.
  - Instantiated once on the MSB digit of the shift registers.
- Remaining logic (FSM, shift registers, counter, output registers) lives in serial_mag_comp.

Test Plan:
- WIDTH=8; a=8'h35, b=8'hB5, start pulse -> done one cycle after acceptance (d=1); lt=1, eq=0, gt=0; busy high exactly 1 cycle.
- a=8'h1F, b=8'h1E -> done after 4 cycles (d=4); gt=1; result held 10 idle cycles after done.
- a=b=8'hA5 -> done after 4 cycles; eq=1. Repeat with a=b=8'h00 and a=b=8'hFF -> eq=1, 4 cycles.
- a=8'h40, b=8'h00 accepted; at cycle 2 drive start=1 with a=8'h00, b=8'hFF -> start ignored; result is gt=1 at d=1, no second done.
- Accept a=8'h03, b=8'h02; assert rst at cycle 2 -> busy=0, done never pulses, lt/eq/gt=000. Next start with a=8'h01, b=8'h02 -> lt=1 after 4 cycles.
- Hold start=1 continuously with a=8'h80, b=8'h7F -> acceptance, gt/done after 1 cycle, immediate re-acceptance; done pulses every 2 cycles, each gt=1.
- Sweep all a,b for WIDTH=2 and WIDTH=4 against a reference model -> one-hot result always matches, latency always equals d.

Source files
------------

// File: rtl/serial_mag_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_mag_comp_pkg
// Purpose  : Shared types and constants for the serial magnitude comparator.
//            Defines the FSM state encoding, the one-hot relation type
//            {lt, eq, gt}, and the relation constants.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package serial_mag_comp_pkg;

    // FSM state encoding
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_SCAN = 1'b1;

    // One-hot relation, MSB first: {lt, eq, gt}
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } rel_t;

    localparam rel_t REL_LT   = 3'b100;
    localparam rel_t REL_EQ   = 3'b010;
    localparam rel_t REL_GT   = 3'b001;
    localparam rel_t REL_NONE = 3'b000;

endpackage : serial_mag_comp_pkg
`default_nettype wire

// File: rtl/comp_digit2.sv
`default_nettype none
// ============================================================================
// Module   : comp_digit2
// Purpose  : Combinational 2-bit unsigned magnitude compare producing a
//            one-hot {lt, eq, gt} relation.
// Ports    : i_a   [1:0]  digit A
//            i_b   [1:0]  digit B
//            o_rel rel_t  one-hot relation of A versus B
// Revision : 1.0 - initial release
// ============================================================================
module comp_digit2
    import serial_mag_comp_pkg::*;
(
    input  logic [1:0] i_a,
    input  logic [1:0] i_b,
    output rel_t       o_rel
);

    always_comb begin
        o_rel = REL_EQ;
        if (i_a < i_b) begin
            o_rel = REL_LT;
        end else if (i_a > i_b) begin
            o_rel = REL_GT;
        end
    end

endmodule : comp_digit2
`default_nettype wire

// File: rtl/serial_mag_comp.sv
`default_nettype none
// ============================================================================
// Module   : serial_mag_comp
// Purpose  : Multi-digit unsigned magnitude comparator. Operands are captured
//            on an accepted start and scanned two bits per clock, MSB digit
//            first; the scan stops at the first differing digit. The result
//            is a registered one-hot {lt, eq, gt} with a one-cycle done pulse.
// Ports    : clk    rising-edge clock
//            rst    synchronous active-high reset
//            start  comparison request, sampled only when idle
//            a, b   [WIDTH-1:0] operands, captured on accepted start
//            busy   high while scanning
//            done   one-cycle pulse when the result becomes valid
//            lt/eq/gt  registered one-hot relation of A versus B
// Revision : 1.0 - initial release
// ============================================================================
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NDIG = WIDTH / 2;
    // Keep the counter at least one bit wide for the single-digit case
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_mag_comp: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    rel_t             r_rel;
    rel_t             w_rel;

    // Only the top digit of each shift register is ever inspected
    comp_digit2 u_digit (
        .i_a   (r_sa[WIDTH-1 -: 2]),
        .i_b   (r_sb[WIDTH-1 -: 2]),
        .o_rel (w_rel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rel   <= REL_NONE;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_cnt   <= CW'(NDIG - 1);
                        r_rel   <= REL_NONE;
                        r_busy  <= 1'b1;
                        r_state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // Decide on the first unequal digit, or on the last digit
                    if ((w_rel != REL_EQ) || (r_cnt == '0)) begin
                        r_rel   <= w_rel;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_sa  <= r_sa << 2;
                        r_sb  <= r_sb << 2;
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign lt   = r_rel.lt;
    assign eq   = r_rel.eq;
    assign gt   = r_rel.gt;

endmodule : serial_mag_comp
`default_nettype wire
